// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branches; each resolution drives the bimodal PHT update port one cycle later.
// Optional statistics counters are enabled with the BRANCH_RESOLVE_STATS_EN macro.
module branch_resolve_queue #(
   parameter int DEPTH     = 8,
   parameter int CNT_NBITS = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 pred_val,
   output logic                 pred_rdy,
   input  logic [31:0]          pred_pc,
   input  logic                 pred_taken,
   input  logic                 resolve_val,
   output logic                 resolve_rdy,
   input  logic                 resolve_taken,
   input  logic                 flush,
   output logic                 update_en,
   output logic                 update_val,
   output logic [31:0]          update_pc,
   output logic                 mispredict,
   output logic [CNT_NBITS-1:0] count_branches,
   output logic [CNT_NBITS-1:0] count_mispred
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   typedef struct packed {
      logic [31:0] pc;
      logic        taken;
   } entry_t;

   entry_t      mem [DEPTH];
   entry_t      head_ent;
   logic [AW:0] head, tail;
   logic        empty, full;
   logic        enq, deq, mis_d;
   logic [1:0]  vld_pipe;

   assign empty = (head == tail);
   assign full  = (head[AW-1:0] == tail[AW-1:0]) && (head[AW] != tail[AW]);

   // The predictor's single PC port is busy for its read-modify-write while update_en is high.
   assign pred_rdy    = !full && !update_en;
   assign resolve_rdy = !empty;

   assign enq      = pred_val && pred_rdy && !flush;
   assign deq      = resolve_val && resolve_rdy;
   assign head_ent = mem[head[AW-1:0]];
   assign mis_d    = deq && (resolve_taken != head_ent.taken);

   assign vld_pipe[0] = deq;
   assign update_en   = vld_pipe[1];

   always_ff @(posedge clk) begin
      if (enq) mem[tail[AW-1:0]] <= '{pc: pred_pc, taken: pred_taken};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head <= '0;
         tail <= '0;
      end else if (flush) begin
         head <= '0;
         tail <= '0;
      end else begin
         if (enq) tail <= tail + PTR_ONE;
         if (deq) head <= head + PTR_ONE;
      end
   end

   // Outputs are zeroed when idle so the predictor port never sees stale data.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_pipe[1] <= 1'b0;
         update_val  <= 1'b0;
         update_pc   <= '0;
         mispredict  <= 1'b0;
      end else begin
         vld_pipe[1] <= vld_pipe[0];
         update_val  <= deq && resolve_taken;
         update_pc   <= deq ? head_ent.pc : 32'h0;
         mispredict  <= mis_d;
      end
   end

`ifdef BRANCH_RESOLVE_STATS_EN
   logic [CNT_NBITS-1:0] cnt_br, cnt_mis;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_br  <= '0;
         cnt_mis <= '0;
      end else begin
         if (deq && !(&cnt_br))    cnt_br  <= cnt_br + CNT_NBITS'(1);
         if (mis_d && !(&cnt_mis)) cnt_mis <= cnt_mis + CNT_NBITS'(1);
      end
   end

   assign count_branches = cnt_br;
   assign count_mispred  = cnt_mis;
`else
   assign count_branches = '0;
   assign count_mispred  = '0;
`endif

endmodule
